// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: streams operand bits LSB first through an external
// combinational full_adder and assembles the WIDTH-bit sum plus carry-out.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin_in,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_a, sh_b, res;
    logic             carry;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        fa_a      = 1'b0;
        fa_b      = 1'b0;
        fa_cin    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SHIFT;
            end
            SHIFT: begin
                busy   = 1'b1;
                fa_a   = sh_a[0];
                fa_b   = sh_b[0];
                fa_cin = carry;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operands shift out LSB first, sum bits shift in from the MSB end,
    // so after WIDTH steps res holds the sum in natural bit order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a     <= '0;
            sh_b     <= '0;
            res      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a  <= op_a;
                        sh_b  <= op_b;
                        carry <= cin_in;
                        cnt   <= '0;
                        res   <= '0;
                    end
                end
                SHIFT: begin
                    sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
                    sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
                    res   <= {fa_sum, res[WIDTH-1:1]};
                    carry <= fa_cout;
                    cnt   <= cnt + 1'b1;
                    // Final bit: publish the completed result as DONE is entered.
                    if (cnt == LAST) begin
                        sum_out  <= {fa_sum, res[WIDTH-1:1]};
                        cout_out <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 and WIDTH=4, each driving a
// behavioural combinational full adder.
module tb_serial_adder_ctrl;

    logic clk, rst;
    int   tests, fails;

    logic       start8, cin8, fa_a8, fa_b8, fa_cin8, fa_sum8, fa_cout8, busy8, done8, cout8;
    logic [7:0] op_a8, op_b8, sum8;
    logic       start4, cin4, fa_a4, fa_b4, fa_cin4, fa_sum4, fa_cout4, busy4, done4, cout4;
    logic [3:0] op_a4, op_b4, sum4;

    assign fa_sum8  = fa_a8 ^ fa_b8 ^ fa_cin8;
    assign fa_cout8 = (fa_a8 & fa_b8) | (fa_a8 & fa_cin8) | (fa_b8 & fa_cin8);
    assign fa_sum4  = fa_a4 ^ fa_b4 ^ fa_cin4;
    assign fa_cout4 = (fa_a4 & fa_b4) | (fa_a4 & fa_cin4) | (fa_b4 & fa_cin4);

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op_a(op_a8), .op_b(op_b8), .cin_in(cin8),
        .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8), .fa_sum(fa_sum8), .fa_cout(fa_cout8),
        .busy(busy8), .done(done8), .sum_out(sum8), .cout_out(cout8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .op_a(op_a4), .op_b(op_b4), .cin_in(cin4),
        .fa_a(fa_a4), .fa_b(fa_b4), .fa_cin(fa_cin4), .fa_sum(fa_sum4), .fa_cout(fa_cout4),
        .busy(busy4), .done(done4), .sum_out(sum4), .cout_out(cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start is sampled at the first edge; SHIFT spans the next 8 cycles, done follows.
    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec);
        op_a8 = a; op_b8 = b; cin8 = c; start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("busy8_shift", busy8, 1);
            chk("done8_shift", done8, 0);
            if (i == 0) begin
                chk("fa_a8_bit0", fa_a8, a[0]);
                chk("fa_b8_bit0", fa_b8, b[0]);
                chk("fa_cin8_bit0", fa_cin8, c);
            end
            @(posedge clk); #1;
        end
        chk("done8_pulse", done8, 1);
        chk("busy8_done", busy8, 0);
        chk("fa_a8_done", fa_a8, 0);
        chk("sum8", sum8, es);
        chk("cout8", cout8, ec);
        @(posedge clk); #1;
        chk("done8_after", done8, 0);
        chk("sum8_hold", sum8, es);
    endtask

    task automatic add4(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] exp;
        exp = {1'b0, a} + {1'b0, b} + {4'b0, c};
        op_a4 = a; op_b4 = b; cin4 = c; start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("busy4_shift", busy4, 1);
            chk("done4_shift", done4, 0);
            @(posedge clk); #1;
        end
        chk("done4_pulse", done4, 1);
        chk("sum4", sum4, exp[3:0]);
        chk("cout4", cout4, exp[4]);
        @(posedge clk); #1;
        chk("done4_after", done4, 0);
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1;
        start8 = 0; op_a8 = 0; op_b8 = 0; cin8 = 0;
        start4 = 0; op_a4 = 0; op_b4 = 0; cin4 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_sum8", sum8, 0);
        chk("rst_cout8", cout8, 0);
        chk("rst_fa8", {fa_a8, fa_b8, fa_cin8}, 0);
        chk("rst_busy4", busy4, 0);
        chk("rst_sum4", sum4, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        add8(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0);
        add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        add8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

        // Start pulse during SHIFT must be ignored; operands stay as captured.
        op_a8 = 8'h10; op_b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        repeat (2) @(posedge clk);
        #1 start8 = 1'b1; op_a8 = 8'hFF;
        @(posedge clk); #1 start8 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("ign_done", done8, 1);
        chk("ign_sum", sum8, 8'h30);
        chk("ign_cout", cout8, 0);
        start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        chk("start_in_done_ignored", busy8, 0);
        add8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

        // Reset mid-operation discards the result.
        op_a8 = 8'hFF; op_b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("mid_rst_busy", busy8, 0);
        chk("mid_rst_done", done8, 0);
        chk("mid_rst_sum", sum8, 0);
        chk("mid_rst_cout", cout8, 0);
        chk("mid_rst_fa", {fa_a8, fa_b8, fa_cin8}, 0);
        add8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        add4(4'hF, 4'hF, 1'b1);
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    add4(4'(a), 4'(b), 1'(c));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller that sits directly upstream of the team's 1-bit full_adder. It accepts two WIDTH-bit operands plus carry-in, feeds one bit pair per clock into the external full_adder (LSB first), registers the returned sum bit and carry, and presents the WIDTH-bit result with carry-out. This trades WIDTH cycles of latency for a single full_adder cell.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 2.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  synchronous reset, active-high
start  input  1  request a new addition; sampled only in IDLE
op_a  input  WIDTH  operand A, captured on accepted start
op_b  input  WIDTH  operand B, captured on accepted start
cin_in  input  1  initial carry-in, captured on accepted start
fa_a  output  1  bit to full_adder a
fa_b  output  1  bit to full_adder b
fa_cin  output  1  carry to full_adder cin
fa_sum  input  1  sum from full_adder
fa_cout  input  1  cout from full_adder
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when the result is valid
sum_out  output  WIDTH  result sum; holds until the next accepted start
cout_out  output  1  final carry-out; holds with sum_out

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst. All state is registered.
- Reset values: state=IDLE; busy=0, done=0, sum_out=0, cout_out=0. fa_a, fa_b and fa_cin are 0. Internal shift registers, carry register and bit counter are 0.
- Internal state:
  - sh_a and sh_b: WIDTH-bit shift registers.
  - res: WIDTH-bit result shift register.
  - carry: 1-bit register.
  - cnt: bit counter, $clog2(WIDTH) bits.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1: load sh_a<=op_a, sh_b<=op_b, carry<=cin_in, cnt<=0, res<=0. Go to SHIFT.
  - On start=0: remain in IDLE.
- SHIFT:
  - busy=1.
  - Combinational drive: fa_a=sh_a[0], fa_b=sh_b[0], fa_cin=carry.
  - Each rising edge:
    - sh_a and sh_b shift right by 1.
    - res <= {fa_sum, res[WIDTH-1:1]}.
    - carry <= fa_cout.
    - cnt <= cnt+1.
  - When cnt==WIDTH-1 at the edge, go to DONE. SHIFT therefore lasts exactly WIDTH cycles.
- DONE:
  - done=1 for exactly one cycle and busy=0.
  - sum_out=res and cout_out=carry are registered on entry to DONE and held thereafter.
  - Next state is IDLE unconditionally. start is ignored in DONE.
- fa_a, fa_b and fa_cin are 0 in every state except SHIFT.
- Latency: start sampled high at edge N. SHIFT occupies cycles N+1..N+WIDTH. done is high in cycle N+WIDTH+1. The next start is accepted at the earliest at edge N+WIDTH+2.
- start while busy or in DONE: ignored. Operands are not recaptured and the operation in progress is unaffected.
- op_a, op_b and cin_in changing after capture: no effect on the result.
- Arithmetic: {cout_out, sum_out} = op_a + op_b + cin_in, computed modulo 2^(WIDTH+1). No saturation.
- Reset mid-operation (any state): next cycle is IDLE with all outputs at reset values. The previous result is discarded. A start after reset behaves normally.
- Reset has priority over start in the same cycle.
- The full_adder is purely combinational. fa_sum and fa_cout are assumed valid within the same cycle that fa_* are driven.

Test Plan:
- WIDTH=8, with the real full_adder connected. op_a=0x3C, op_b=0x42, cin_in=0, start pulsed at edge 0 -> busy high for cycles 1..8; done pulse in cycle 9 only; sum_out=0x7E, cout_out=0.
- WIDTH=8. 0xFF+0x01, cin_in=0 -> sum_out=0x00, cout_out=1. Carry ripples through all 8 bits.
- WIDTH=8. 0xA5+0x5A, cin_in=1 -> sum_out=0x00, cout_out=1. Checks that cin_in enters bit 0.
- WIDTH=8. Start 0x10+0x20, then pulse start with op_a=0xFF in cycle 3 -> ignored; sum_out=0x30 at done. A new start in the cycle after DONE is accepted.
- WIDTH=8. Start 0xFF+0xFF, assert rst in cycle 4 -> in cycle 5, busy=0, done=0, sum_out=0, cout_out=0. The following 0x01+0x01 gives sum_out=0x02.
- WIDTH=4. 0xF+0xF, cin_in=1 -> done in cycle 5; sum_out=0xF, cout_out=1. Exhaustive 4-bit sweep matches a+b+cin.
